// File: rtl/uart_pkg.sv
// Shared types for the parametrised UART receiver: parity modes, receiver
// FSM states and the FIFO entry layout.
package uart_pkg;

    typedef enum logic [1:0] {
        PARITY_NONE,
        PARITY_EVEN,
        PARITY_ODD
    } parity_mode_e;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BRK_WAIT
    } rx_state_e;

    localparam int ENTRY_DATA_W = 9;

    // Data is always 9 bits wide; narrower frames leave the MSBs at 0.
    typedef struct packed {
        logic                    frame_err;
        logic                    parity_err;
        logic [ENTRY_DATA_W-1:0] data;
    } rx_entry_t;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Small first-word-fall-through FIFO. The head entry is visible on rd_data
// whenever valid is high; pop advances to the next entry on the following cycle.
module uart_rx_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             valid,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic             empty;
    logic             do_push;
    logic             do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign valid   = ~empty;
    assign rd_data = mem[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_frame.sv
// Parametrised UART receiver: majority-voted sampling, parity/framing flags,
// break detection and a receive FIFO behind a valid/ready interface.
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int           CLOCK_FREQUENCY = 1_000_000,
    parameter int           BAUD_RATE       = 12_000,
    parameter int           DATA_BITS       = 8,
    parameter parity_mode_e PARITY_MODE     = PARITY_NONE,
    parameter int           STOP_BITS       = 1,
    parameter int           FIFO_DEPTH      = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_uart_rx,
    output logic [DATA_BITS-1:0] o_rx_data,
    output logic                 o_parity_err,
    output logic                 o_frame_err,
    output logic                 o_rx_valid,
    input  logic                 i_rx_ready,
    output logic                 o_overrun,
    output logic                 o_break
);
    localparam int CLOCKS_PER_BAUD = CLOCK_FREQUENCY / BAUD_RATE;
    localparam int DIV_W           = $clog2(CLOCKS_PER_BAUD);
    localparam int MAX_CNT         = (DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS;
    localparam int CNT_W           = $clog2(MAX_CNT);
    localparam logic [DIV_W-1:0] HALF_LOAD = DIV_W'(CLOCKS_PER_BAUD / 2 - 1);
    localparam logic [DIV_W-1:0] FULL_LOAD = DIV_W'(CLOCKS_PER_BAUD - 1);

    if (CLOCKS_PER_BAUD < 8) begin : g_chk_baud
        $error("uart_rx_frame: CLOCKS_PER_BAUD must be at least 8");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_chk_data
        $error("uart_rx_frame: DATA_BITS must be 5..9");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_chk_stop
        $error("uart_rx_frame: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chk_fifo
        $error("uart_rx_frame: FIFO_DEPTH must be a power of two >= 2");
    end

    // Synchroniser plus two history taps; the taps double as edge-detect memory.
    logic sync1_reg, sync2_reg, hist1_reg, hist2_reg;
    logic fall, bit_val, strobe;

    rx_state_e              state_reg, state_next;
    logic [DIV_W-1:0]       div_reg, div_next;
    logic [CNT_W-1:0]       cnt_reg, cnt_next;
    logic [DATA_BITS-1:0]   shift_reg, shift_next;
    logic                   perr_reg, perr_next;
    logic                   ferr_reg, ferr_next;
    logic                   any_one_reg, any_one_next;
    logic                   overrun_reg, overrun_next;
    logic                   break_reg, break_next;
    logic                   push;
    logic                   fifo_full;
    logic                   fifo_valid;
    rx_entry_t              wr_entry;
    rx_entry_t              head;
    logic                   unused_head_bits;

    assign fall    = hist1_reg & ~sync2_reg;
    assign bit_val = majority3(sync2_reg, hist1_reg, hist2_reg);
    assign strobe  = (div_reg == '0);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync1_reg <= 1'b1;
            sync2_reg <= 1'b1;
            hist1_reg <= 1'b1;
            hist2_reg <= 1'b1;
        end else begin
            sync1_reg <= i_uart_rx;
            sync2_reg <= sync1_reg;
            hist1_reg <= sync2_reg;
            hist2_reg <= hist1_reg;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg   <= IDLE;
            div_reg     <= '0;
            cnt_reg     <= '0;
            shift_reg   <= '0;
            perr_reg    <= 1'b0;
            ferr_reg    <= 1'b0;
            any_one_reg <= 1'b0;
            overrun_reg <= 1'b0;
            break_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            div_reg     <= div_next;
            cnt_reg     <= cnt_next;
            shift_reg   <= shift_next;
            perr_reg    <= perr_next;
            ferr_reg    <= ferr_next;
            any_one_reg <= any_one_next;
            overrun_reg <= overrun_next;
            break_reg   <= break_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        div_next     = div_reg;
        cnt_next     = cnt_reg;
        shift_next   = shift_reg;
        perr_next    = perr_reg;
        ferr_next    = ferr_reg;
        any_one_next = any_one_reg;
        overrun_next = 1'b0;
        break_next   = 1'b0;
        push         = 1'b0;

        if (state_reg != IDLE && state_reg != BRK_WAIT) begin
            div_next = strobe ? FULL_LOAD : div_reg - 1'b1;
        end

        case (state_reg)
            IDLE: begin
                if (fall) begin
                    state_next   = START;
                    div_next     = HALF_LOAD;
                    cnt_next     = '0;
                    perr_next    = 1'b0;
                    ferr_next    = 1'b0;
                    any_one_next = 1'b0;
                end
            end
            START: begin
                if (strobe) begin
                    if (bit_val) state_next = IDLE;
                    else         state_next = DATA;
                end
            end
            DATA: begin
                if (strobe) begin
                    shift_next   = {bit_val, shift_reg[DATA_BITS-1:1]};
                    any_one_next = any_one_reg | bit_val;
                    if (cnt_reg == CNT_W'(DATA_BITS - 1)) begin
                        cnt_next = '0;
                        if (PARITY_MODE != PARITY_NONE) state_next = PARITY;
                        else                            state_next = STOP;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (strobe) begin
                    perr_next    = ((^shift_reg) ^ bit_val) != (PARITY_MODE == PARITY_ODD);
                    any_one_next = any_one_reg | bit_val;
                    state_next   = STOP;
                end
            end
            STOP: begin
                if (strobe) begin
                    ferr_next = ferr_reg | ~bit_val;
                    if (cnt_reg == CNT_W'(STOP_BITS - 1)) begin
                        cnt_next = '0;
                        // An all-zero frame including its stop bits is a break, not data.
                        if (!any_one_reg && !bit_val) begin
                            break_next = 1'b1;
                            state_next = BRK_WAIT;
                        end else begin
                            if (fifo_full) overrun_next = 1'b1;
                            else           push         = 1'b1;
                            state_next = IDLE;
                        end
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end
            BRK_WAIT: begin
                if (sync2_reg) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign wr_entry.frame_err  = ferr_reg | ~bit_val;
    assign wr_entry.parity_err = perr_reg;
    assign wr_entry.data       = ENTRY_DATA_W'(shift_reg);

    uart_rx_fifo #(
        .WIDTH ($bits(rx_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (i_clk),
        .rst     (i_rst),
        .push    (push),
        .wr_data (wr_entry),
        .pop     (i_rx_ready),
        .rd_data (head),
        .valid   (fifo_valid),
        .full    (fifo_full)
    );

    // Gate the head so an empty FIFO (including right after reset) shows zeros.
    assign o_rx_valid       = fifo_valid;
    assign o_rx_data        = fifo_valid ? head.data[DATA_BITS-1:0] : '0;
    assign o_parity_err     = fifo_valid & head.parity_err;
    assign o_frame_err      = fifo_valid & head.frame_err;
    assign o_overrun        = overrun_reg;
    assign o_break          = break_reg;
    assign unused_head_bits = ^head.data;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame: three configurations (8N1, 8E1, 7O2)
// driven with hand-built frames and checked against hand-computed entries.
module tb_uart_rx_frame;

    localparam int CPB = 83;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic rx_a = 1'b1, rx_b = 1'b1, rx_c = 1'b1;
    logic ready_a = 1'b1, ready_b = 1'b1, ready_c = 1'b1;
    logic [7:0] data_a, data_b;
    logic [6:0] data_c;
    logic perr_a, ferr_a, valid_a, ovr_a, brk_a;
    logic perr_b, ferr_b, valid_b, ovr_b, brk_b;
    logic perr_c, ferr_c, valid_c, ovr_c, brk_c;

    uart_rx_frame #(.DATA_BITS(8), .PARITY_MODE(uart_pkg::PARITY_NONE), .STOP_BITS(1)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_uart_rx(rx_a), .o_rx_data(data_a),
        .o_parity_err(perr_a), .o_frame_err(ferr_a), .o_rx_valid(valid_a),
        .i_rx_ready(ready_a), .o_overrun(ovr_a), .o_break(brk_a));

    uart_rx_frame #(.DATA_BITS(8), .PARITY_MODE(uart_pkg::PARITY_EVEN), .STOP_BITS(1)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_uart_rx(rx_b), .o_rx_data(data_b),
        .o_parity_err(perr_b), .o_frame_err(ferr_b), .o_rx_valid(valid_b),
        .i_rx_ready(ready_b), .o_overrun(ovr_b), .o_break(brk_b));

    uart_rx_frame #(.DATA_BITS(7), .PARITY_MODE(uart_pkg::PARITY_ODD), .STOP_BITS(2)) dut_c (
        .i_clk(clk), .i_rst(rst), .i_uart_rx(rx_c), .o_rx_data(data_c),
        .o_parity_err(perr_c), .o_frame_err(ferr_c), .o_rx_valid(valid_c),
        .i_rx_ready(ready_c), .o_overrun(ovr_c), .o_break(brk_c));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: records every accepted entry and counts pulses, sampled mid-cycle.
    logic [10:0] q_a[$], q_b[$], q_c[$];
    int ovr_cnt_a = 0, brk_cnt_a = 0, vcyc_a = 0, rise_a = 0;
    logic valid_a_d = 1'b0;

    always @(negedge clk) begin
        if (valid_a && ready_a) q_a.push_back({ferr_a, perr_a, 1'b0, data_a});
        if (valid_b && ready_b) q_b.push_back({ferr_b, perr_b, 1'b0, data_b});
        if (valid_c && ready_c) q_c.push_back({ferr_c, perr_c, 2'b00, data_c});
        if (ovr_a) ovr_cnt_a <= ovr_cnt_a + 1;
        if (brk_a) brk_cnt_a <= brk_cnt_a + 1;
        if (valid_a) vcyc_a <= vcyc_a + 1;
        if (valid_a && !valid_a_d) rise_a <= cyc;
        valid_a_d <= valid_a;
    end

    int pass_cnt = 0;
    int total_cnt = 0;
    int start_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    endtask

    task automatic set_line(input int inst, input logic v);
        case (inst)
            0: rx_a = v;
            1: rx_b = v;
            default: rx_c = v;
        endcase
    endtask

    // inst 0 = 8N1, 1 = 8E1, 2 = 7O2
    task automatic send_frame(input int inst, input logic [8:0] d, input logic par,
                              input logic s1, input logic s2);
        logic [12:0] bits;
        int nd;
        int n;
        nd = (inst == 2) ? 7 : 8;
        bits = '0;
        bits[0] = 1'b0;
        for (int i = 0; i < nd; i++) bits[1 + i] = d[i];
        n = 1 + nd;
        if (inst != 0) begin bits[n] = par; n++; end
        bits[n] = s1; n++;
        if (inst == 2) begin bits[n] = s2; n++; end
        @(negedge clk);
        start_cyc = cyc;
        for (int i = 0; i < n; i++) begin
            set_line(inst, bits[i]);
            repeat (CPB) @(negedge clk);
        end
        set_line(inst, 1'b1);
    endtask

    task automatic take_entry(input int inst, output logic [10:0] e, output int n);
        e = '0;
        case (inst)
            0: begin n = q_a.size(); if (n > 0) e = q_a.pop_front(); end
            1: begin n = q_b.size(); if (n > 0) e = q_b.pop_front(); end
            default: begin n = q_c.size(); if (n > 0) e = q_c.pop_front(); end
        endcase
    endtask

    task automatic expect_entry(input string tag, input int inst, input logic [8:0] d,
                                input logic pe, input logic fe);
        logic [10:0] e;
        int n;
        take_entry(inst, e, n);
        $display("txn %s: inst=%0d entries=%0d data=0x%0h perr=%0b ferr=%0b",
                 tag, inst, n, e[8:0], e[9], e[10]);
        check({tag, "_count"}, n, 1);
        check({tag, "_data"}, e[8:0], d);
        check({tag, "_perr"}, e[9], pe);
        check({tag, "_ferr"}, e[10], fe);
    endtask

    typedef struct {
        int         inst;
        logic [8:0] data;
        logic       par;
        logic       s1;
        logic       s2;
        logic [8:0] exp_data;
        logic       exp_perr;
        logic       exp_ferr;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int vc0, br0;
        logic [10:0] e;
        int n;

        vecs[0] = '{1, 9'h03, 1'b1, 1'b1, 1'b1, 9'h03, 1'b1, 1'b0};
        vecs[1] = '{1, 9'h07, 1'b1, 1'b1, 1'b1, 9'h07, 1'b0, 1'b0};
        vecs[2] = '{0, 9'h55, 1'b0, 1'b0, 1'b1, 9'h55, 1'b0, 1'b1};
        vecs[3] = '{2, 9'h41, 1'b1, 1'b1, 1'b0, 9'h41, 1'b0, 1'b1};
        vecs[4] = '{2, 9'h41, 1'b0, 1'b1, 1'b1, 9'h41, 1'b1, 1'b0};
        vecs[5] = '{1, 9'h80, 1'b0, 1'b1, 1'b1, 9'h80, 1'b1, 1'b0};
        vecs[6] = '{2, 9'h2A, 1'b0, 1'b1, 1'b1, 9'h2A, 1'b0, 1'b0};
        vecs[7] = '{0, 9'hFF, 1'b0, 1'b1, 1'b1, 9'hFF, 1'b0, 1'b0};

        repeat (5) @(negedge clk);
        check("rst_valid", valid_a, 0);
        check("rst_data", data_a, 0);
        check("rst_perr", perr_a, 0);
        check("rst_ferr", ferr_a, 0);
        check("rst_overrun", ovr_a, 0);
        check("rst_break", brk_a, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // 8N1 0xA5: 2 sync + 41 to first strobe + 9 bit times + 1 = 791 cycles
        vc0 = vcyc_a;
        send_frame(0, 9'hA5, 1'b0, 1'b1, 1'b1);
        repeat (20) @(negedge clk);
        check("a5_latency", rise_a - start_cyc, 791);
        check("a5_valid_cycles", vcyc_a - vc0, 1);
        expect_entry("a5", 0, 9'hA5, 1'b0, 1'b0);

        for (int i = 0; i < 8; i++) begin
            send_frame(vecs[i].inst, vecs[i].data, vecs[i].par, vecs[i].s1, vecs[i].s2);
            repeat (20) @(negedge clk);
            expect_entry($sformatf("vec%0d", i), vecs[i].inst, vecs[i].exp_data,
                         vecs[i].exp_perr, vecs[i].exp_ferr);
        end

        // False start: 20-cycle glitch is gone by the mid-bit strobe.
        @(negedge clk);
        rx_a = 1'b0;
        repeat (20) @(negedge clk);
        rx_a = 1'b1;
        repeat (200) @(negedge clk);
        $display("txn glitch: entries=%0d valid=%0b", q_a.size(), valid_a);
        check("glitch_entries", q_a.size(), 0);
        check("glitch_valid", valid_a, 0);
        send_frame(0, 9'h3C, 1'b0, 1'b1, 1'b1);
        repeat (20) @(negedge clk);
        expect_entry("after_glitch", 0, 9'h3C, 1'b0, 1'b0);

        // Overrun: four frames fill the FIFO, the fifth is dropped.
        @(posedge clk); #1 ready_a = 1'b0;
        for (int i = 1; i <= 4; i++) send_frame(0, 9'(i), 1'b0, 1'b1, 1'b1);
        repeat (20) @(negedge clk);
        check("ovr_none_yet", ovr_cnt_a, 0);
        send_frame(0, 9'h05, 1'b0, 1'b1, 1'b1);
        repeat (20) @(negedge clk);
        $display("txn overrun: pulses=%0d valid=%0b", ovr_cnt_a, valid_a);
        check("ovr_pulses", ovr_cnt_a, 1);
        check("ovr_valid_held", valid_a, 1);
        @(posedge clk); #1 ready_a = 1'b1;
        repeat (20) @(negedge clk);
        check("ovr_drain_count", q_a.size(), 4);
        for (int i = 1; i <= 4; i++) begin
            take_entry(0, e, n);
            $display("txn drain: data=0x%0h", e[8:0]);
            check($sformatf("ovr_drain%0d", i), e[8:0], 9'(i));
        end

        // Break: line low for 15 bit times.
        br0 = brk_cnt_a;
        @(negedge clk);
        rx_a = 1'b0;
        repeat (15 * CPB) @(negedge clk);
        rx_a = 1'b1;
        repeat (300) @(negedge clk);
        $display("txn break: pulses=%0d entries=%0d", brk_cnt_a - br0, q_a.size());
        check("brk_pulses", brk_cnt_a - br0, 1);
        check("brk_entries", q_a.size(), 0);
        check("brk_valid", valid_a, 0);
        send_frame(0, 9'hC3, 1'b0, 1'b1, 1'b1);
        repeat (20) @(negedge clk);
        expect_entry("after_break", 0, 9'hC3, 1'b0, 1'b0);

        // Reset mid-byte with one entry still queued.
        @(posedge clk); #1 ready_a = 1'b0;
        send_frame(0, 9'h11, 1'b0, 1'b1, 1'b1);
        repeat (20) @(negedge clk);
        check("pre_rst_valid", valid_a, 1);
        @(negedge clk);
        rx_a = 1'b0;
        repeat (4 * CPB) @(negedge clk);
        rst = 1'b1;
        rx_a = 1'b1;
        repeat (3) @(negedge clk);
        $display("txn reset: valid=%0b data=0x%0h", valid_a, data_a);
        check("mid_rst_valid", valid_a, 0);
        check("mid_rst_data", data_a, 0);
        check("mid_rst_flags", {perr_a, ferr_a}, 0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        @(posedge clk); #1 ready_a = 1'b1;
        send_frame(0, 9'h5A, 1'b0, 1'b1, 1'b1);
        repeat (20) @(negedge clk);
        expect_entry("after_rst", 0, 9'h5A, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
